pir_zone_alarm: RTL

- Parametrised successor to the three-sensor PIR alarm: N zones of SENSOR_W-bit PIR samples.
- Per-zone threshold compare and debounce; a global arm/alarm/holdoff FSM drives the buzzer.
- Per-zone latched LEDs and a saturating per-zone trip counter shown on 7-segment digits.
- Sits between the sensor front-end and the board LED, buzzer and display drivers.

---
 rtl/pir_zone_alarm_if.sv | 26 ++
 rtl/pir_zone_alarm.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/pir_zone_alarm_if.sv
// Bus between the PIR sensor front-end and the zone alarm: sensor samples and controls in,
// LED / buzzer / 7-seg digits out, plus the FSM state for observation.
interface pir_zone_alarm_if #(
  parameter int NUM_ZONES = 3,
  parameter int SENSOR_W  = 7
);
  // No valid/ready handshake: every input is a level sampled on each rising clk edge, and
  // every output is a register that holds its value until the next edge.
  logic                          turn;
  logic                          stop_alarm;
  logic [NUM_ZONES*SENSOR_W-1:0] pir_sensor;
  logic [NUM_ZONES-1:0]          LED;
  logic                          buzzer;
  logic [NUM_ZONES*7-1:0]        display_data;
  logic [1:0]                    state_dbg;

  modport master (
    output turn, stop_alarm, pir_sensor,
    input  LED, buzzer, display_data, state_dbg
  );

  modport slave (
    input  turn, stop_alarm, pir_sensor,
    output LED, buzzer, display_data, state_dbg
  );
endinterface

// File: rtl/pir_zone_alarm.sv
// N-zone PIR alarm: per-zone threshold and debounce, global arm/alarm/holdoff FSM,
// latched zone LEDs, and a saturating per-zone trip count shown on 7-segment digits.
module pir_zone_alarm #(
  parameter int NUM_ZONES = 3,
  parameter int SENSOR_W  = 7,
  parameter int THRESHOLD = 64,
  parameter int DEBOUNCE  = 4,
  parameter int BUZZ_DIV  = 2,
  parameter int HOLDOFF   = 8
) (
  input logic               clk,
  input logic               rst_n,
  pir_zone_alarm_if.slave   bus
);

  localparam int DW = $clog2(DEBOUNCE + 1);
  localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam int BW = (BUZZ_DIV > 1) ? $clog2(BUZZ_DIV) : 1;
  localparam logic [SENSOR_W-1:0] THR     = SENSOR_W'(THRESHOLD);
  localparam logic [DW-1:0]       DEB_MAX = DW'(DEBOUNCE);
  localparam logic [DW-1:0]       DEB_PRE = DW'(DEBOUNCE - 1);
  localparam logic [HW-1:0]       HO_LAST = HW'(HOLDOFF - 1);
  localparam logic [BW-1:0]       BZ_LAST = BW'(BUZZ_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_ALARM   = 2'd2,
    S_HOLDOFF = 2'd3
  } state_t;

  state_t                 state;
  logic [DW-1:0]          deb [NUM_ZONES];
  logic [3:0]             count [NUM_ZONES];
  logic [3:0]             count_nxt [NUM_ZONES];
  logic [HW-1:0]          hcnt;
  logic [BW-1:0]          bcnt;
  logic [NUM_ZONES-1:0]   led;
  logic                   buzzer;
  logic [NUM_ZONES*7-1:0] disp;
  logic [NUM_ZONES-1:0]   hit;
  logic [NUM_ZONES-1:0]   trip;
  logic                   counting;
  logic                   take;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      default: s = 7'h6F;
    endcase
    return s;
  endfunction

  // A trip is only accepted when turn is high and, in ALARM, stop_alarm is low.
  always_comb begin
    counting = (state == S_ARMED) || (state == S_ALARM);
    take     = bus.turn && ((state == S_ARMED) ||
                            ((state == S_ALARM) && !bus.stop_alarm));
    hit  = '0;
    trip = '0;
    for (int i = 0; i < NUM_ZONES; i++) begin
      count_nxt[i] = count[i];
      hit[i]  = bus.pir_sensor[i*SENSOR_W +: SENSOR_W] >= THR;
      trip[i] = counting && hit[i] && (deb[i] == DEB_PRE);
      if (take && trip[i] && (count[i] != 4'd9))
        count_nxt[i] = count[i] + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      led    <= '0;
      buzzer <= 1'b0;
      hcnt   <= '0;
      bcnt   <= '0;
      for (int i = 0; i < NUM_ZONES; i++) begin
        deb[i]          <= '0;
        count[i]        <= 4'd0;
        disp[i*7 +: 7]  <= 7'h3F;
      end
    end else begin
      for (int i = 0; i < NUM_ZONES; i++) begin
        if (counting && hit[i])
          deb[i] <= (deb[i] == DEB_MAX) ? deb[i] : deb[i] + DW'(1);
        else
          deb[i] <= '0;
        count[i]       <= count_nxt[i];
        disp[i*7 +: 7] <= seg7(count_nxt[i]);
      end

      if (!bus.turn) begin
        state  <= S_IDLE;
        led    <= '0;
        buzzer <= 1'b0;
        hcnt   <= '0;
        bcnt   <= '0;
      end else begin
        case (state)
          S_IDLE: state <= S_ARMED;
          S_ARMED: begin
            if (|trip) begin
              state  <= S_ALARM;
              led    <= trip;
              buzzer <= 1'b1;
              bcnt   <= '0;
            end
          end
          S_ALARM: begin
            if (bus.stop_alarm) begin
              state  <= S_HOLDOFF;
              led    <= '0;
              buzzer <= 1'b0;
              hcnt   <= '0;
            end else begin
              led <= led | trip;
              // Square wave: hold each level for BUZZ_DIV cycles.
              if (bcnt == BZ_LAST) begin
                buzzer <= ~buzzer;
                bcnt   <= '0;
              end else begin
                bcnt <= bcnt + BW'(1);
              end
            end
          end
          S_HOLDOFF: begin
            if (hcnt == HO_LAST) begin
              state <= S_ARMED;
              hcnt  <= '0;
            end else begin
              hcnt <= hcnt + HW'(1);
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.LED          = led;
  assign bus.buzzer       = buzzer;
  assign bus.display_data = disp;
  assign bus.state_dbg    = state;

endmodule
